// File: rtl/ecd_msg_assembler.sv
// Collects 8-beat, 32-bit AXI-Stream packets from the ECD link into 256-bit
// messages with framing checks and a one-message output holding register.
module ecd_msg_assembler #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 256,
  parameter int BEATS     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  AXIS_IN_TDATA,
  input  logic                 AXIS_IN_TVALID,
  input  logic                 AXIS_IN_TLAST,
  output logic                 AXIS_IN_TREADY,
  output logic [OUT_WIDTH-1:0] AXIS_OUT_TDATA,
  output logic                 AXIS_OUT_TVALID,
  input  logic                 AXIS_OUT_TREADY,
  output logic [15:0]          framing_errors,
  output logic                 dbg_state
);

  // Handshakes: a transfer happens on a rising edge where TVALID and TREADY
  // are both high; TDATA is held stable while TVALID is high and TREADY low.

  typedef enum logic {
    COLLECT = 1'b0,
    DISCARD = 1'b1
  } state_t;

  localparam int       STAGE_W   = (BEATS - 1) * IN_WIDTH;
  localparam bit [2:0] LAST_BEAT = 3'(BEATS - 1);

  state_t                state_q, state_d;
  logic [2:0]            beat_cnt_q, beat_cnt_d;
  logic [STAGE_W-1:0]    stage_q, stage_d;
  logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic                  out_full_q, out_full_d;
  logic                  in_ready_q, in_ready_d;
  logic [15:0]           err_q, err_d;
  logic                  in_acc;
  logic                  err_inc;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    stage_d    = stage_q;
    out_data_d = out_data_q;
    out_full_d = out_full_q;
    err_d      = err_q;
    err_inc    = 1'b0;
    in_acc     = AXIS_IN_TVALID & in_ready_q;

    if (out_full_q && AXIS_OUT_TREADY) begin
      out_full_d = 1'b0;
    end

    if (in_acc) begin
      if (state_q == DISCARD) begin
        if (AXIS_IN_TLAST) begin
          beat_cnt_d = 3'd0;
          state_d    = COLLECT;
        end
      end else if (beat_cnt_q != LAST_BEAT) begin
        if (AXIS_IN_TLAST) begin
          err_inc    = 1'b1;
          beat_cnt_d = 3'd0;
        end else begin
          for (int i = 0; i < BEATS - 1; i++) begin
            if (beat_cnt_q == i[2:0]) begin
              stage_d[i*IN_WIDTH +: IN_WIDTH] = AXIS_IN_TDATA;
            end
          end
          beat_cnt_d = beat_cnt_q + 3'd1;
        end
      end else if (AXIS_IN_TLAST) begin
        // Good packet; a simultaneous out acceptance is overridden by the reload.
        out_data_d = {AXIS_IN_TDATA, stage_q};
        out_full_d = 1'b1;
        beat_cnt_d = 3'd0;
      end else begin
        err_inc = 1'b1;
        state_d = DISCARD;
      end
    end

    if (err_inc && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end

    // Looking at next-state values keeps beat 7 off a full register without
    // a combinational path from AXIS_OUT_TREADY to AXIS_IN_TREADY.
    in_ready_d = (state_d == DISCARD) ||
                 !((beat_cnt_d == LAST_BEAT) && out_full_d && !AXIS_OUT_TREADY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= COLLECT;
      beat_cnt_q <= 3'd0;
      stage_q    <= '0;
      out_data_q <= '0;
      out_full_q <= 1'b0;
      in_ready_q <= 1'b0;
      err_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      stage_q    <= stage_d;
      out_data_q <= out_data_d;
      out_full_q <= out_full_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
    end
  end

  assign AXIS_IN_TREADY  = in_ready_q;
  assign AXIS_OUT_TDATA  = out_data_q;
  assign AXIS_OUT_TVALID = out_full_q;
  assign framing_errors  = err_q;
  assign dbg_state       = (state_q == DISCARD);

endmodule

// File: doc/ecd_msg_assembler.md
# ecd_msg_assembler

Assembles the 32-bit AXI-Stream word stream arriving from the ECD link into 256-bit messages and presents them to the event broker's 256-bit AXI-Stream input. Each 8-beat packet, delimited by TLAST, becomes one message. The block checks packet framing, discards malformed packets and counts them. A one-message output holding register lets the next packet be collected while the broker is still busy with the current one.

## Interface
- IN_WIDTH, 32: input word width; fixed at 32.
- OUT_WIDTH, 256: output message width; fixed at 256.
- BEATS, 8: input beats per message; equals OUT_WIDTH/IN_WIDTH.

- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- AXIS_IN_TDATA  in  32  input word from the ECD link.
- AXIS_IN_TVALID  in  1  input word valid.
- AXIS_IN_TLAST  in  1  marks the last word of a packet.
- AXIS_IN_TREADY  out  1  block can accept an input word.
- AXIS_OUT_TDATA  out  256  assembled message; bits [255:248] carry the message type.
- AXIS_OUT_TVALID  out  1  message valid.
- AXIS_OUT_TREADY  in  1  downstream has accepted the message.
- framing_errors  out  16  saturating count of discarded packets.

## Operation
- Beat acceptance: a beat is accepted when AXIS_IN_TVALID & AXIS_IN_TREADY are both high.
- Word order:
  - beat k (0..7) of a packet lands in message bits [32k+31:32k].
  - beat 0 is the least-significant word; beat 7 carries the message-type byte.
- beat_cnt: 3 bits; counts accepted beats of the current packet.
- State COLLECT:
  - Beat accepted with beat_cnt<7 and TLAST=0: store the word; increment beat_cnt.
  - Beat accepted with beat_cnt<7 and TLAST=1 (short packet):
    - discard the partial message;
    - increment framing_errors;
    - clear beat_cnt; stay in COLLECT.
  - Beat accepted with beat_cnt==7 and TLAST=1 (good packet):
    - transfer the 7 stored words plus this word to the output register;
    - set out_full; clear beat_cnt.
  - Beat accepted with beat_cnt==7 and TLAST=0 (long packet):
    - discard the message;
    - increment framing_errors;
    - go to DISCARD.
- State DISCARD:
  - Accept and drop every beat.
  - On an accepted beat with TLAST=1: clear beat_cnt and go to COLLECT.
  - A long packet adds exactly one error, however long it is.
- Output holding register:
  - AXIS_OUT_TVALID = out_full.
  - AXIS_OUT_TDATA stays stable while TVALID is high and TREADY is low.
  - Out acceptance (TVALID & TREADY) clears out_full, unless a new good packet completes in the same cycle; then the register reloads and out_full stays 1.
- AXIS_IN_TREADY:
  - In COLLECT: low only when beat_cnt==7 and out_full is set and AXIS_OUT_TREADY is low.
  - In DISCARD: always high.
  - AXIS_IN_TREADY is registered. It is computed from next-state values, so it never combinationally depends on AXIS_OUT_TREADY.
- framing_errors saturates at 16'hFFFF and clears only on reset.
- The message contents are not interpreted; type bytes 0, 1 and any others pass through unchanged.

## Timing
- Reset (asynchronous assert; release synchronised to clk):
  - AXIS_IN_TREADY=0, AXIS_OUT_TVALID=0, AXIS_OUT_TDATA=0, framing_errors=0;
  - beat_cnt=0, state COLLECT, out_full=0.
- AXIS_IN_TREADY goes to 1 on the first clk edge after reset deasserts.
- Latency: AXIS_OUT_TVALID rises on the clk edge that accepts beat 7. The message is visible the cycle after the last beat is presented.
- Throughput: one input beat per clk when downstream always accepts, giving one message per 8 cycles with no bubbles.
- Backpressure:
  - While out_full is set, beats 0..6 of the next packet are still accepted.
  - Only beat 7 stalls, and it stalls for as long as the output is held.
- Mid-operation reset:
  - Any partial message and any held output are lost.
  - AXIS_OUT_TVALID drops asynchronously.
  - No message is emitted for beats received before reset.
- A TVALID/TLAST change while TREADY is low has no effect on state.

## Test plan
- Good packet, TREADY=1: send words 0x00000001..0x00000008 with TLAST on the 8th -> one message; TDATA[31:0]=1, TDATA[255:224]=8; TVALID high 1 cycle after beat 8; framing_errors=0.
- Back-to-back, TREADY=1: 3 packets in 24 consecutive cycles -> 3 messages in order, no input stall, TREADY never low.
- Backpressure: hold AXIS_OUT_TREADY=0 during packet 2 -> message 1 TDATA stable; beats 0..6 of packet 2 accepted; beat 7 stalls; release -> message 1 accepted, then message 2 appears.
- Short packet: TLAST on beat 3, then a good packet -> only the good packet is output; framing_errors=1.
- Long packet: 11 beats with TLAST on the 11th, then a good packet -> one message (the good one); framing_errors=1.
- Reset mid-packet: reset after 4 beats, then a good packet -> TVALID=0 immediately; the only message is the post-reset one; framing_errors=0.
